// File: rtl/mem_arbiter_mc.sv
// Two-port arbiter (core vs external loader) for the unified memory of the multi-cycle core.
// Optional macro ARB_FAIR_EN bounds consecutive ext grants while the core waits.
module mem_arbiter_mc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [1:0]        core_size,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [1:0]        ext_size,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic              ext_err,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
    $error("mem_arbiter_mc: MEM_LAT must be in 1..15");
  end
  if (MAX_CONSEC < 1) begin : g_bad_consec
    $error("mem_arbiter_mc: MAX_CONSEC must be at least 1");
  end

  // Size 11 is illegal; half and word accesses must be naturally aligned.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  state_t            state_r;
  logic [3:0]        lat_cnt_r;
  logic              any_req_s;
  logic              pick_ext_s;
  logic              core_forced_s;
  logic              sel_we_s;
  logic              sel_bad_s;
  logic [1:0]        sel_size_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // Winner selection and request field mux, evaluated only when the FSM is in IDLE
  always_comb begin
    any_req_s  = core_req | ext_req;
    pick_ext_s = ext_req & ~core_forced_s;
    if (pick_ext_s) begin
      sel_we_s    = ext_we;
      sel_size_s  = ext_size;
      sel_addr_s  = ext_addr;
      sel_wdata_s = ext_wdata;
    end else begin
      sel_we_s    = core_we;
      sel_size_s  = core_size;
      sel_addr_s  = core_addr;
      sel_wdata_s = core_wdata;
    end
    sel_bad_s = access_bad(sel_size_s, sel_addr_s[1:0]);
  end

`ifdef ARB_FAIR_EN
  localparam int CONSEC_W = $clog2(MAX_CONSEC + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_CONSEC);

  logic [CONSEC_W-1:0] consec_ext_r;

  assign core_forced_s = core_req & (consec_ext_r == CONSEC_MAX);

  // Counts ext grants made while the core was left waiting; any core grant or uncontested ext grant clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      consec_ext_r <= {CONSEC_W{1'b0}};
    end else if (state_r == ST_IDLE && any_req_s) begin
      if (!pick_ext_s || !core_req) begin
        consec_ext_r <= {CONSEC_W{1'b0}};
      end else if (consec_ext_r != CONSEC_MAX) begin
        consec_ext_r <= consec_ext_r + {{(CONSEC_W-1){1'b0}}, 1'b1};
      end else begin
        consec_ext_r <= consec_ext_r;
      end
    end else begin
      consec_ext_r <= consec_ext_r;
    end
  end
`else
  assign core_forced_s = 1'b0;
`endif

  // Transaction FSM; every output is a register updated on the state transition that produces it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lat_cnt_r  <= 4'd0;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= {DATA_W{1'b0}};
      ext_ack    <= 1'b0;
      ext_err    <= 1'b0;
      ext_rdata  <= {DATA_W{1'b0}};
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_size   <= 2'b00;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
      busy       <= 1'b0;
      grant      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant <= pick_ext_s;
            busy  <= 1'b1;
            if (sel_bad_s) begin
              // Rejected accesses never reach the memory port
              state_r  <= ST_ERR;
              core_ack <= ~pick_ext_s;
              core_err <= ~pick_ext_s;
              ext_ack  <= pick_ext_s;
              ext_err  <= pick_ext_s;
            end else begin
              state_r   <= ST_ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= sel_we_s;
              mem_size  <= sel_size_s;
              mem_addr  <= sel_addr_s;
              mem_wdata <= sel_wdata_s;
            end
          end
        end
        ST_ISSUE: begin
          mem_en <= 1'b0;
          if (mem_we) begin
            state_r  <= ST_RESP;
            core_ack <= ~grant;
            ext_ack  <= grant;
          end else begin
            state_r   <= ST_WAIT;
            lat_cnt_r <= 4'(MEM_LAT);
          end
        end
        ST_WAIT: begin
          lat_cnt_r <= lat_cnt_r - 4'd1;
          if (lat_cnt_r == 4'd1) begin
            state_r <= ST_RESP;
            if (grant) begin
              ext_rdata <= mem_rdata;
              ext_ack   <= 1'b1;
            end else begin
              core_rdata <= mem_rdata;
              core_ack   <= 1'b1;
            end
          end
        end
        ST_RESP, ST_ERR: begin
          state_r  <= ST_IDLE;
          core_ack <= 1'b0;
          core_err <= 1'b0;
          ext_ack  <= 1'b0;
          ext_err  <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          core_ack <= 1'b0;
          core_err <= 1'b0;
          ext_ack  <= 1'b0;
          ext_err  <= 1'b0;
          mem_en   <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_mc.sv
// Bench for mem_arbiter_mc: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3.
// Expected responses are queued at request time and checked when the acks appear.
module tb_mem_arbiter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        core_req   [2];
  logic        core_we    [2];
  logic [1:0]  core_size  [2];
  logic [31:0] core_addr  [2];
  logic [31:0] core_wdata [2];
  logic        core_ack   [2];
  logic        core_err   [2];
  logic [31:0] core_rdata [2];
  logic        ext_req    [2];
  logic        ext_we     [2];
  logic [1:0]  ext_size   [2];
  logic [31:0] ext_addr   [2];
  logic [31:0] ext_wdata  [2];
  logic        ext_ack    [2];
  logic        ext_err    [2];
  logic [31:0] ext_rdata  [2];
  logic        mem_en     [2];
  logic        mem_we     [2];
  logic [1:0]  mem_size   [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic [31:0] mem_rdata  [2];
  logic        busy       [2];
  logic        grant      [2];

  mem_arbiter_mc #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_CONSEC(4)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .core_req(core_req[0]), .core_we(core_we[0]), .core_size(core_size[0]),
    .core_addr(core_addr[0]), .core_wdata(core_wdata[0]),
    .core_ack(core_ack[0]), .core_err(core_err[0]), .core_rdata(core_rdata[0]),
    .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_size(ext_size[0]),
    .ext_addr(ext_addr[0]), .ext_wdata(ext_wdata[0]),
    .ext_ack(ext_ack[0]), .ext_err(ext_err[0]), .ext_rdata(ext_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_size(mem_size[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .grant(grant[0])
  );

  mem_arbiter_mc #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_CONSEC(4)) u_lat3 (
    .clk(clk), .rst(rst[1]),
    .core_req(core_req[1]), .core_we(core_we[1]), .core_size(core_size[1]),
    .core_addr(core_addr[1]), .core_wdata(core_wdata[1]),
    .core_ack(core_ack[1]), .core_err(core_err[1]), .core_rdata(core_rdata[1]),
    .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_size(ext_size[1]),
    .ext_addr(ext_addr[1]), .ext_wdata(ext_wdata[1]),
    .ext_ack(ext_ack[1]), .ext_err(ext_err[1]), .ext_rdata(ext_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_size(mem_size[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .grant(grant[1])
  );

  typedef struct {
    int          dut;
    bit          port;   // 0 core, 1 ext
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
    int          en_cyc;
    int          ack_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_on   = 1'b0;
  logic        prev_en     [2];
  int          last_en_cyc [2];
  logic [31:0] last_rdata  [2][2];
  logic [31:0] model [logic [31:0]];
  logic [31:0] pipe  [2][3];
  bit          log_q[$];
  int          ack_a, ack_b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_val(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    if (size == 2'b01 && addr[0] == 1'b1) return 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Memory macro model: read data appears exactly MEM_LAT cycles after mem_en, junk otherwise
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][2] <= pipe[d][1];
      pipe[d][1] <= pipe[d][0];
      pipe[d][0] <= (mem_en[d] === 1'b1 && mem_we[d] === 1'b0) ? model_val(mem_addr[d]) : 32'hBAD0_BAD0;
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: checks every memory strobe and every ack against the queued expectation
  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        if (mem_en[d] === 1'b1) begin
          if (prev_en[d] === 1'b1) check("en_overlap", 64'(mem_en[d]), 64'd0);
          last_en_cyc[d] <= cyc;
          if (sb_q.size() == 0 || sb_q[0].dut != d || sb_q[0].err) begin
            check("spurious_en", 64'(mem_en[d]), 64'd0);
          end else begin
            check("en_cycle", 64'(cyc), 64'(sb_q[0].en_cyc));
            check("mem_addr", 64'(mem_addr[d]), 64'(sb_q[0].addr));
            check("mem_we", 64'(mem_we[d]), 64'(sb_q[0].we));
            check("mem_size", 64'(mem_size[d]), 64'(sb_q[0].size));
            if (sb_q[0].we) check("mem_wdata", 64'(mem_wdata[d]), 64'(sb_q[0].wdata));
          end
        end
        if (core_ack[d] === 1'b1 || ext_ack[d] === 1'b1) begin
          if (sb_q.size() == 0 || sb_q[0].dut != d) begin
            check("spurious_ack", 64'({core_ack[d], ext_ack[d]}), 64'd0);
          end else begin
            mon_e = sb_q.pop_front();
            check("ack_port", 64'({core_ack[d], ext_ack[d]}), mon_e.port ? 64'd1 : 64'd2);
            check("ack_cycle", 64'(cyc), 64'(mon_e.ack_cyc));
            check("grant", 64'(grant[d]), 64'(mon_e.port));
            check("err", 64'({core_err[d], ext_err[d]}),
                  mon_e.err ? (mon_e.port ? 64'd1 : 64'd2) : 64'd0);
            check("rdata", 64'(mon_e.port ? ext_rdata[d] : core_rdata[d]), 64'(mon_e.rdata));
          end
        end
        prev_en[d] <= mem_en[d];
      end
    end
  end

  // One complete request on one port: queue expectation, drive, wait (bounded) for ack, release
  task automatic do_req(input int d, input bit p, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, output int ack_at);
    exp_t e;
    bit   got;
    int   lat;
    lat       = (d == 0) ? 1 : 3;
    e.dut     = d;
    e.port    = p;
    e.we      = we;
    e.size    = size;
    e.addr    = addr;
    e.wdata   = wdata;
    e.err     = is_bad(size, addr);
    e.en_cyc  = e.err ? -1 : cyc + 1;
    e.ack_cyc = e.err ? cyc + 1 : (we ? cyc + 2 : cyc + lat + 2);
    if (e.err || we) begin
      e.rdata = last_rdata[d][p];
    end else begin
      e.rdata = model_val(addr);
      last_rdata[d][p] = e.rdata;
    end
    if (!e.err && we) model[addr] = wdata;
    sb_q.push_back(e);
    if (p) begin
      ext_req[d] = 1'b1; ext_we[d] = we; ext_size[d] = size; ext_addr[d] = addr; ext_wdata[d] = wdata;
    end else begin
      core_req[d] = 1'b1; core_we[d] = we; core_size[d] = size; core_addr[d] = addr; core_wdata[d] = wdata;
    end
    got    = 1'b0;
    ack_at = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if ((p ? ext_ack[d] : core_ack[d]) === 1'b1) begin
        got    = 1'b1;
        ack_at = cyc;
      end
    end
    if (!got) check("ack_timeout", 64'(got), 64'd1);
    if (p) ext_req[d] = 1'b0;
    else core_req[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      core_req[d] = 1'b0; core_we[d] = 1'b0; core_size[d] = 2'b00; core_addr[d] = 32'd0; core_wdata[d] = 32'd0;
      ext_req[d]  = 1'b0; ext_we[d]  = 1'b0; ext_size[d]  = 2'b00; ext_addr[d]  = 32'd0; ext_wdata[d]  = 32'd0;
      prev_en[d] = 1'b0; last_en_cyc[d] = -1;
      last_rdata[d][0] = 32'd0; last_rdata[d][1] = 32'd0;
    end
    model[32'h0000_0100] = 32'hDEAD_BEEF;
    model[32'h0000_0400] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_ctrl", 64'({core_ack[0], core_err[0], ext_ack[0], ext_err[0], mem_en[0], mem_we[0],
                          mem_size[0], busy[0], grant[0]}), 64'd0);
    check("rst_core_rdata", 64'(core_rdata[0]), 64'd0);
    check("rst_ext_rdata", 64'(ext_rdata[0]), 64'd0);
    check("rst_mem_addr", 64'(mem_addr[0]), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata[0]), 64'd0);
    check("rst_busy_lat3", 64'({busy[1], mem_en[1], core_ack[1], ext_ack[1]}), 64'd0);
    mon_on = 1'b1;

    // Basic read, store, rejected accesses
    do_req(0, 1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'd0, ack_a);
    do_req(0, 1'b1, 1'b1, 2'b01, 32'h0000_0202, 32'h0000_1234, ack_a);
    do_req(0, 1'b0, 1'b0, 2'b10, 32'h0000_0103, 32'd0, ack_a);
    check("err_rdata_kept", 64'(core_rdata[0]), 64'hDEAD_BEEF);
    do_req(0, 1'b0, 1'b0, 2'b11, 32'h0000_0100, 32'd0, ack_a);
    check("err11_rdata_kept", 64'(core_rdata[0]), 64'hDEAD_BEEF);
    do_req(0, 1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'd0, ack_a);
    do_req(0, 1'b0, 1'b0, 2'b00, 32'h0000_0105, 32'd0, ack_a);
    do_req(0, 1'b1, 1'b0, 2'b10, 32'h0000_0206, 32'd0, ack_a);

    // Ext ack then core request in the following cycle
    do_req(0, 1'b1, 1'b1, 2'b10, 32'h0000_0208, 32'h1111_2222, ack_a);
    do_req(0, 1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'd0, ack_b);
    check("b2b_en_gap", 64'(last_en_cyc[0] - ack_a), 64'd2);

    // Both ports requesting continuously
    mon_on = 1'b0;
    core_req[0] = 1'b1; core_we[0] = 1'b1; core_size[0] = 2'b10; core_addr[0] = 32'h0000_0300; core_wdata[0] = 32'h0000_0C0C;
    ext_req[0]  = 1'b1; ext_we[0]  = 1'b1; ext_size[0]  = 2'b10; ext_addr[0]  = 32'h0000_0304; ext_wdata[0]  = 32'h0000_0E0E;
    for (int k = 0; k < 200 && log_q.size() < 10; k++) begin
      @(posedge clk); #1;
      if (core_ack[0] === 1'b1) log_q.push_back(1'b0);
      else if (ext_ack[0] === 1'b1) log_q.push_back(1'b1);
    end
    core_req[0] = 1'b0; ext_req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    prev_en[0] = 1'b0;
    mon_on = 1'b1;
    if (log_q.size() < 10) check("arb_timeout", 64'(log_q.size()), 64'd10);
    for (int k = 0; k < log_q.size(); k++) begin
`ifdef ARB_FAIR_EN
      check($sformatf("arb_grant_%0d", k), 64'(log_q[k]), (k % 5 == 4) ? 64'd0 : 64'd1);
`else
      check($sformatf("arb_grant_%0d", k), 64'(log_q[k]), 64'd1);
`endif
    end

    // Store then read back on the core port
    do_req(0, 1'b0, 1'b1, 2'b10, 32'h0000_010C, 32'hA5A5_0F0F, ack_a);
    do_req(0, 1'b0, 1'b0, 2'b10, 32'h0000_010C, 32'd0, ack_a);

    // MEM_LAT=3: normal read, then reset while waiting, then a fresh read
    do_req(1, 1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'd0, ack_a);
    begin
      exp_t e;
      e.dut = 1; e.port = 1'b0; e.we = 1'b0; e.size = 2'b10; e.addr = 32'h0000_0404;
      e.wdata = 32'd0; e.err = 1'b0; e.rdata = 32'd0; e.en_cyc = cyc + 1; e.ack_cyc = -1;
      sb_q.push_back(e);
    end
    core_req[1] = 1'b1; core_we[1] = 1'b0; core_size[1] = 2'b10; core_addr[1] = 32'h0000_0404;
    repeat (3) @(posedge clk);
    #1;
    check("wait_busy", 64'(busy[1]), 64'd1);
    rst[1] = 1'b1;
    core_req[1] = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check("abort_busy", 64'(busy[1]), 64'd0);
    check("abort_ack", 64'({core_ack[1], ext_ack[1], mem_en[1]}), 64'd0);
    check("abort_rdata", 64'(core_rdata[1]), 64'd0);
    last_rdata[1][0] = 32'd0; last_rdata[1][1] = 32'd0;
    repeat (5) @(posedge clk);
    #1;
    do_req(1, 1'b0, 1'b0, 2'b10, 32'h0000_0408, 32'd0, ack_a);
    do_req(1, 1'b1, 1'b1, 2'b00, 32'h0000_0409, 32'h0000_00AB, ack_a);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_mc.md
Name: mem_arbiter_mc

Overview:
- Arbitrates the single unified instruction/data memory of the multi-cycle core between two requesters: the core's memory port (fetch, load, store) and an external loader/debug port.
- Sequences each access through issue, latency-wait and response phases, and returns read data with a one-cycle ack.
- Rejects misaligned or illegal-size accesses without touching memory.
- Sits between the core's memory-control outputs and the memory macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15
MAX_CONSEC, 4, consecutive ext grants allowed while core waits (only with ARB_FAIR_EN)

Ports:
clk  in  1  clock
rst  in  1  reset: rst, synchronous, active-high; clock clk
core_req  in  1  core access request, held until core_ack
core_we  in  1  1=store, 0=load/fetch
core_size  in  2  00 byte, 01 half, 10 word, 11 illegal
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  store data
core_ack  out  1  one-cycle completion pulse
core_err  out  1  valid with core_ack: access rejected
core_rdata  out  DATA_W  read data, valid with core_ack
ext_req, ext_we, ext_size, ext_addr, ext_wdata  in  same widths as core_*  external port request
ext_ack, ext_err  out  1  as core_*
ext_rdata  out  DATA_W  as core_rdata
mem_en  out  1  one-cycle access strobe
mem_we  out  1  write enable, qualified by mem_en
mem_size  out  2  access size
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  valid exactly MEM_LAT cycles after mem_en
busy  out  1  high in any state other than IDLE
grant  out  1  owner of the current transaction: 0 core, 1 ext

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latency counter and consecutive-grant counter 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE
  - Samples core_req and ext_req. If neither is high, stay in IDLE.
  - Winner selection: ext beats core unless fairness overrides (see Optional Feature).
  - Latch the winner's we/size/addr/wdata and set grant.
  - Alignment check: size 11 is illegal; half with addr[0]=1 is misaligned; word with addr[1:0]!=0 is misaligned. Illegal or misaligned -> ERR. Otherwise -> ISSUE.
- ISSUE
  - mem_en=1 for exactly one cycle; mem_* driven from latched values.
  - Write -> RESP. Read -> WAIT with counter loaded to MEM_LAT.
- WAIT
  - Counter decrements each cycle.
  - When it reaches 0, capture mem_rdata into the granted requester's rdata register -> RESP.
- RESP: the granted requester's ack=1 and err=0 for one cycle -> IDLE.
- ERR: the granted requester's ack=1 and err=1 for one cycle; rdata is unchanged; no mem_en issued -> IDLE.
- Latency, counted from the cycle req is sampled in IDLE (cycle 0):
  - mem_en in cycle 1.
  - Write ack in cycle 2.
  - Read ack in cycle MEM_LAT+2.
  - Error ack in cycle 1.
- Handshake rules:
  - Requester holds req and its fields stable until ack, then deasserts req or presents a new request starting in the cycle after ack.
  - req is ignored in every state other than IDLE.
  - The losing requester stays pending and is served next time the FSM enters IDLE. A new request can therefore start the cycle after any ack.
- rdata registers hold their last value between acks.
- Simultaneous core_req and ext_req in IDLE resolve by the priority rule only; there is never a double grant.
- rst in any state: return to IDLE the next cycle, drop mem_en and acks, abandon the in-flight transaction, clear counters and rdata registers.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined:
  - consec_ext counter (width clog2(MAX_CONSEC+1)) increments on each ext grant made while core_req is high, saturating at MAX_CONSEC.
  - It clears on any core grant, and on an ext grant while core_req is low.
  - If consec_ext==MAX_CONSEC and core_req is high in IDLE, core wins.
- Undefined: strict ext priority; core can be starved indefinitely; the counter is not instantiated.

Test Plan:
- Core word read, addr 0x100, MEM_LAT=1, mem_rdata=0xDEADBEEF -> mem_en cycle 1 with mem_addr=0x100 and mem_we=0; core_ack cycle 3 with core_rdata=0xDEADBEEF and core_err=0.
- Ext half store, addr 0x202, wdata 0x1234 -> mem_en=1, mem_we=1, mem_size=01 in cycle 1; ext_ack cycle 2.
- Core word read, addr 0x103 -> core_ack=1, core_err=1 in cycle 1; mem_en never asserted; core_rdata unchanged. Repeat with size 11 -> same response.
- Both ports request continuously, ARB_FAIR_EN undefined -> all grants go to ext. With ARB_FAIR_EN defined and MAX_CONSEC=4 -> grant sequence ext,ext,ext,ext,core repeating.
- MEM_LAT=3 read with rst asserted in WAIT -> next cycle busy=0, no ack, rdata=0; a fresh request afterwards completes normally with ack at cycle 5.
- Ext ack followed by a core request issued in the cycle after ack -> core mem_en exactly 2 cycles after ext_ack; no overlap of mem_en between transactions.
